// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: funct3 size codes, FSM states
// and request kinds, plus funct3 legality helpers.
package mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    RS_IDLE = 3'd0,
    RS_BUSY = 3'd1,
    RS_RESP = 3'd2
  } rstate_t;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_t;

  function automatic logic loadF3Legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic storeF3Legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data for
// stores, lane select plus sign/zero extension for loads, misalignment flag.
module lsu_align
  import mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] rawWord,
  input  logic [31:0] wdata,
  output logic [3:0]  byteEn,
  output logic [31:0] storeWord,
  output logic [31:0] loadWord,
  output logic        misalign
);

  logic [31:0] shifted;

  // The selected lane is moved down to bit 0 before extension.
  always_comb begin
    shifted   = rawWord >> {addrLo, 3'b000};
    byteEn    = 4'b0000;
    storeWord = wdata;
    loadWord  = 32'h0;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        byteEn    = 4'b0001 << addrLo;
        storeWord = {4{wdata[7:0]}};
        loadWord  = funct3[2] ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        misalign  = addrLo[0];
        byteEn    = addrLo[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{wdata[15:0]}};
        loadWord  = funct3[2] ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        misalign  = (addrLo != 2'b00);
        byteEn    = 4'b1111;
        loadWord  = rawWord;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one request, waits WAIT_CYCLES, then
// answers with a one-cycle memReady strobe from a single-port word RAM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        isFetch,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        memReady,
  output logic        memErr,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram [DEPTH];
  rstate_t       state;
  logic [3:0]    cnt;
  logic [AW+1:0] capAddr;
  logic [31:0]   capWdata;
  logic [2:0]    capF3;
  kind_t         capKind;
  logic          capErr;

  logic          inIdle, anyStrobe, multiStrobe, outOfRange, illegalF3, liveErr;
  logic [1:0]    nStrobes;
  kind_t         liveKind, respKind;
  logic [2:0]    liveF3, curF3;
  logic [1:0]    curLo;
  logic [AW-1:0] curIdx;
  logic [31:0]   curWdata, rawWord, respData;
  logic          respErr;
  logic [3:0]    byteEn;
  logic [31:0]   storeWord, loadWord;
  logic          misalign;

  // In IDLE the datapath looks at the live request so that a zero-wait
  // response can be formed on the capture edge; otherwise at the captured one.
  always_comb begin
    nStrobes    = 2'(isFetch) + 2'(memRead) + 2'(memWrite);
    anyStrobe   = (nStrobes != 2'd0);
    multiStrobe = (nStrobes > 2'd1);
    liveKind    = isFetch ? KIND_FETCH : (memWrite ? KIND_STORE : KIND_LOAD);
    liveF3      = isFetch ? F3_W : funct3;
    outOfRange  = ((addr >> (AW + 2)) != 32'h0);
    illegalF3   = 1'b0;
    case (liveKind)
      KIND_LOAD:  illegalF3 = !loadF3Legal(funct3);
      KIND_STORE: illegalF3 = !storeF3Legal(funct3);
      default:    illegalF3 = 1'b0;
    endcase
    inIdle   = (state == RS_IDLE);
    curLo    = inIdle ? addr[1:0] : capAddr[1:0];
    curIdx   = inIdle ? addr[AW+1:2] : capAddr[AW+1:2];
    curF3    = inIdle ? liveF3 : capF3;
    curWdata = inIdle ? wdata : capWdata;
    respKind = inIdle ? liveKind : capKind;
  end

  assign rawWord = ram[curIdx];

  lsu_align u_align (
    .funct3   (curF3),
    .addrLo   (curLo),
    .rawWord  (rawWord),
    .wdata    (curWdata),
    .byteEn   (byteEn),
    .storeWord(storeWord),
    .loadWord (loadWord),
    .misalign (misalign)
  );

  assign liveErr  = multiStrobe | outOfRange | illegalF3 | misalign;
  assign respErr  = inIdle ? liveErr : capErr;
  assign respData = (respErr || respKind == KIND_STORE) ? 32'h0 : loadWord;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state    <= RS_IDLE;
      cnt      <= 4'd0;
      capAddr  <= '0;
      capWdata <= 32'h0;
      capF3    <= 3'b000;
      capKind  <= KIND_FETCH;
      capErr   <= 1'b0;
      rdata    <= 32'h0;
      memReady <= 1'b0;
      memErr   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      memReady <= 1'b0;
      case (state)
        RS_IDLE: begin
          if (anyStrobe) begin
            capAddr  <= addr[AW+1:0];
            capWdata <= wdata;
            capF3    <= liveF3;
            capKind  <= liveKind;
            capErr   <= liveErr;
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state    <= RS_RESP;
              memReady <= 1'b1;
              memErr   <= respErr;
              rdata    <= respData;
            end else begin
              state <= RS_BUSY;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        RS_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= RS_RESP;
            memReady <= 1'b1;
            memErr   <= respErr;
            rdata    <= respData;
          end
        end
        RS_RESP: begin
          state  <= RS_IDLE;
          busy   <= 1'b0;
          memErr <= 1'b0;
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

  // Stores commit only on the edge that leaves RESP; an async reset during
  // BUSY/RESP forces IDLE first, so an aborted store never lands.
  always_ff @(posedge CLK) begin
    if (state == RS_RESP && capKind == KIND_STORE && !capErr) begin
      for (int k = 0; k < 4; k++) begin
        if (byteEn[k]) ram[curIdx][8*k +: 8] <= storeWord[8*k +: 8];
      end
    end
  end

endmodule
